pcie_s10_msi_arb: RTL and testbench

Multi-source MSI interrupt arbiter for the Stratix 10 H-tile `app_msi_*` interface, replacing the single hard-wired interrupt source in the DMA benchmark core. It collects up to IRQ_COUNT interrupt sources, latches them as pending, round-robin arbitrates among unmasked pending sources, and drives the hard IP request/acknowledge handshake. It adds per-source masking, multiple-message vector folding and an acknowledge timeout. It sits between the DMA engine/status logic and the H-tile MSI ports inside `dma_bench_pcie_s10`.

---
 rtl/pcie_s10_msi_arb.sv | 181 ++++++++++++++++++
 tb/tb_pcie_s10_msi_arb.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_s10_msi_arb.sv
// Multi-source MSI arbiter for the H-tile app_msi_* port: latches per-source
// interrupts, round-robin grants unmasked pending sources, runs the req/ack handshake.
//
// Handshake: app_msi_req rises with a stable app_msi_num and stays high until
// app_msi_ack is sampled high (transfer done) or the ack timeout expires; req then
// stays low for at least two cycles before the next request.
module pcie_s10_msi_arb #(
    parameter int         IRQ_COUNT    = 32,
    parameter logic [2:0] MSI_TC       = 3'd0,
    parameter logic [1:0] MSI_FUNC_NUM = 2'd0,
    parameter int         ACK_TIMEOUT  = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IRQ_COUNT-1:0] irq_req,
    input  logic [IRQ_COUNT-1:0] irq_mask,
    input  logic                 msi_enable,
    input  logic [2:0]           msi_mme,
    output logic [IRQ_COUNT-1:0] irq_pending,
    output logic                 irq_sent,
    output logic                 irq_timeout,
    output logic                 app_msi_req,
    input  logic                 app_msi_ack,
    output logic [2:0]           app_msi_tc,
    output logic [4:0]           app_msi_num,
    output logic [1:0]           app_msi_func_num
);

    localparam int PW = (IRQ_COUNT > 1) ? $clog2(IRQ_COUNT) : 1;
    localparam int TW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
    localparam logic [PW-1:0] PTR_LAST = PW'(IRQ_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;

    logic [IRQ_COUNT-1:0] pend_q;
    logic [IRQ_COUNT-1:0] elig;
    logic [IRQ_COUNT-1:0] clr;
    logic [PW-1:0]        rr_ptr_q;
    logic [PW-1:0]        grant_q;
    logic [PW-1:0]        arb_idx;
    logic [PW-1:0]        cand_idx;
    logic                 arb_found;
    int                   cand;
    logic [TW-1:0]        tmo_cnt_q;
    logic                 tmo_hit;
    logic [4:0]           num_q;
    logic [4:0]           num_mask;
    logic [4:0]           arb_num;
    logic                 sent_q;
    logic                 tmo_q;
    logic                 do_grant;
    logic                 do_ack;
    logic                 do_tmo;

    assign elig = msi_enable ? (pend_q & ~irq_mask) : '0;

    // Rotating priority: first eligible index at or after rr_ptr, wrapping at IRQ_COUNT.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 0; i < IRQ_COUNT; i++) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= IRQ_COUNT) begin
                cand = cand - IRQ_COUNT;
            end
            cand_idx = PW'(cand);
            if (!arb_found && elig[cand_idx]) begin
                arb_found = 1'b1;
                arb_idx   = cand_idx;
            end
        end
    end

    // Fold the source index onto the 2^min(mme,5) vectors the host allocated.
    always_comb begin
        num_mask = 5'h1f;
        case (msi_mme)
            3'd0:    num_mask = 5'h00;
            3'd1:    num_mask = 5'h01;
            3'd2:    num_mask = 5'h03;
            3'd3:    num_mask = 5'h07;
            3'd4:    num_mask = 5'h0f;
            default: num_mask = 5'h1f;
        endcase
    end

    assign arb_num = 5'(arb_idx) & num_mask;
    assign tmo_hit = (ACK_TIMEOUT > 0) && (tmo_cnt_q == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Ack wins over a timeout expiring in the same cycle; neither aborts on mask/enable.
    always_comb begin
        state_d  = state_q;
        do_grant = 1'b0;
        do_ack   = 1'b0;
        do_tmo   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    do_grant = 1'b1;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                if (app_msi_ack) begin
                    do_ack  = 1'b1;
                    state_d = ST_GAP;
                end else if (tmo_hit) begin
                    do_tmo  = 1'b1;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        clr = '0;
        if (do_ack) begin
            clr[grant_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q    <= '0;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            num_q     <= '0;
            tmo_cnt_q <= '0;
            sent_q    <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            // A new request on the acked source in the ack cycle survives the clear.
            pend_q <= (pend_q & ~clr) | irq_req;
            sent_q <= do_ack;
            tmo_q  <= do_tmo;
            if (do_grant) begin
                grant_q   <= arb_idx;
                num_q     <= arb_num;
                tmo_cnt_q <= '0;
            end else if ((ACK_TIMEOUT > 0) && (state_q == ST_REQ) && !app_msi_ack) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
            if (do_ack) begin
                rr_ptr_q <= (grant_q == PTR_LAST) ? '0 : grant_q + 1'b1;
            end
        end
    end

    assign irq_pending      = pend_q;
    assign irq_sent         = sent_q;
    assign irq_timeout      = tmo_q;
    assign app_msi_req      = (state_q == ST_REQ);
    assign app_msi_num      = num_q;
    assign app_msi_tc       = MSI_TC;
    assign app_msi_func_num = MSI_FUNC_NUM;

endmodule

// File: tb/tb_pcie_s10_msi_arb.sv
// Directed vector bench for pcie_s10_msi_arb: cycle-by-cycle table of inputs and
// expected outputs, plus a hand-written asynchronous reset-during-request sequence.
module tb_pcie_s10_msi_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] irq_req = '0;
    logic [31:0] irq_mask = '0;
    logic        msi_enable = 1'b0;
    logic [2:0]  msi_mme = 3'd0;
    logic [31:0] irq_pending;
    logic        irq_sent;
    logic        irq_timeout;
    logic        app_msi_req;
    logic        app_msi_ack = 1'b0;
    logic [2:0]  app_msi_tc;
    logic [4:0]  app_msi_num;
    logic [1:0]  app_msi_func_num;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        rst;
        logic [31:0] req;
        logic [31:0] mask;
        logic        en;
        logic [2:0]  mme;
        logic        ack;
        logic        x_req;
        logic [4:0]  x_num;
        logic        x_sent;
        logic        x_tmo;
        logic [31:0] x_pend;
    } vec_t;

    vec_t vq[$];

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    pcie_s10_msi_arb #(
        .IRQ_COUNT   (32),
        .MSI_TC      (3'd5),
        .MSI_FUNC_NUM(2'd2),
        .ACK_TIMEOUT (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .irq_req         (irq_req),
        .irq_mask        (irq_mask),
        .msi_enable      (msi_enable),
        .msi_mme         (msi_mme),
        .irq_pending     (irq_pending),
        .irq_sent        (irq_sent),
        .irq_timeout     (irq_timeout),
        .app_msi_req     (app_msi_req),
        .app_msi_ack     (app_msi_ack),
        .app_msi_tc      (app_msi_tc),
        .app_msi_num     (app_msi_num),
        .app_msi_func_num(app_msi_func_num)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        irq_req     = '0;
        app_msi_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int rst, input int req, input int mask, input int en,
                       input int mme, input int ack, input int xr, input int xn,
                       input int xs, input int xt, input int xp);
        vec_t v;
        v.rst    = 1'(rst);
        v.req    = 32'(req);
        v.mask   = 32'(mask);
        v.en     = 1'(en);
        v.mme    = 3'(mme);
        v.ack    = 1'(ack);
        v.x_req  = 1'(xr);
        v.x_num  = 5'(xn);
        v.x_sent = 1'(xs);
        v.x_tmo  = 1'(xt);
        v.x_pend = 32'(xp);
        vq.push_back(v);
    endtask

    initial begin
        int n;

        // single source: irq 3, mme=5, ack after 4 request cycles
        add(1, 32'h8, 0, 1, 5, 0,   0, 0, 0, 0, 32'h8);
        for (int k = 0; k < 4; k++) add(0, 0, 0, 1, 5, 0,   1, 3, 0, 0, 32'h8);
        add(0, 0, 0, 1, 5, 1,   0, 0, 1, 0, 0);
        add(0, 0, 0, 1, 5, 0,   0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 5, 0,   0, 0, 0, 0, 0);

        // round robin 0, 5, 31 then 0, 5 with immediate acks
        add(1, 32'h80000021, 0, 1, 5, 0,   0, 0, 0, 0, 32'h80000021);
        add(0, 0, 0, 1, 5, 0,   1, 0, 0, 0, 32'h80000021);
        add(0, 0, 0, 1, 5, 1,   0, 0, 1, 0, 32'h80000020);
        add(0, 0, 0, 1, 5, 0,   0, 0, 0, 0, 32'h80000020);
        add(0, 0, 0, 1, 5, 0,   1, 5, 0, 0, 32'h80000020);
        add(0, 0, 0, 1, 5, 1,   0, 0, 1, 0, 32'h80000000);
        add(0, 0, 0, 1, 5, 0,   0, 0, 0, 0, 32'h80000000);
        add(0, 0, 0, 1, 5, 0,   1, 31, 0, 0, 32'h80000000);
        add(0, 0, 0, 1, 5, 1,   0, 0, 1, 0, 0);
        add(0, 32'h21, 0, 1, 5, 0,   0, 0, 0, 0, 32'h21);
        add(0, 0, 0, 1, 5, 0,   1, 0, 0, 0, 32'h21);
        add(0, 0, 0, 1, 5, 1,   0, 0, 1, 0, 32'h20);
        add(0, 0, 0, 1, 5, 0,   0, 0, 0, 0, 32'h20);
        add(0, 0, 0, 1, 5, 0,   1, 5, 0, 0, 32'h20);
        add(0, 0, 0, 1, 5, 1,   0, 0, 1, 0, 0);
        add(0, 0, 0, 1, 5, 0,   0, 0, 0, 0, 0);

        // masking and vector folding, mme=2; mask and mme change mid-request
        add(1, 32'h220, 32'h20, 1, 2, 0,   0, 0, 0, 0, 32'h220);
        add(0, 0, 32'h20, 1, 2, 0,   1, 1, 0, 0, 32'h220);
        add(0, 0, 32'h20, 1, 2, 1,   0, 0, 1, 0, 32'h20);
        add(0, 0, 32'h20, 1, 2, 0,   0, 0, 0, 0, 32'h20);
        add(0, 0, 32'h20, 1, 2, 0,   0, 0, 0, 0, 32'h20);
        add(0, 0, 0, 1, 2, 0,        1, 1, 0, 0, 32'h20);
        add(0, 0, 32'h20, 1, 0, 0,   1, 1, 0, 0, 32'h20);
        add(0, 0, 32'h20, 1, 0, 1,   0, 0, 1, 0, 0);
        add(0, 0, 0, 1, 2, 0,        0, 0, 0, 0, 0);

        // timeout: req held exactly 16 cycles, pending kept, re-request 2 cycles later
        add(1, 32'h80, 0, 1, 5, 0,   0, 0, 0, 0, 32'h80);
        for (int k = 0; k < 16; k++) add(0, 0, 0, 1, 5, 0,   1, 7, 0, 0, 32'h80);
        add(0, 0, 0, 1, 5, 0,   0, 0, 0, 1, 32'h80);
        add(0, 0, 0, 1, 5, 0,   0, 0, 0, 0, 32'h80);
        add(0, 0, 0, 1, 5, 0,   1, 7, 0, 0, 32'h80);
        add(0, 0, 0, 1, 5, 1,   0, 0, 1, 0, 0);
        add(0, 0, 0, 1, 5, 0,   0, 0, 0, 0, 0);

        // new request on source 2 in its own ack cycle stays pending
        add(1, 32'h4, 0, 1, 5, 0,   0, 0, 0, 0, 32'h4);
        add(0, 0, 0, 1, 5, 0,       1, 2, 0, 0, 32'h4);
        add(0, 32'h4, 0, 1, 5, 1,   0, 0, 1, 0, 32'h4);
        add(0, 0, 0, 1, 5, 0,       0, 0, 0, 0, 32'h4);
        add(0, 0, 0, 1, 5, 0,       1, 2, 0, 0, 32'h4);
        add(0, 0, 0, 1, 5, 1,       0, 0, 1, 0, 0);
        add(0, 0, 0, 1, 5, 0,       0, 0, 0, 0, 0);

        // msi_enable low: pending accumulates, stray ack ignored; enable drop mid-request
        add(1, 32'h2, 0, 0, 5, 0,    0, 0, 0, 0, 32'h2);
        add(0, 32'h40, 0, 0, 5, 0,   0, 0, 0, 0, 32'h42);
        add(0, 0, 0, 0, 5, 1,        0, 0, 0, 0, 32'h42);
        add(0, 0, 0, 0, 5, 0,        0, 0, 0, 0, 32'h42);
        add(0, 0, 0, 1, 5, 0,        1, 1, 0, 0, 32'h42);
        add(0, 0, 0, 0, 5, 0,        1, 1, 0, 0, 32'h42);
        add(0, 0, 0, 0, 5, 1,        0, 0, 1, 0, 32'h40);
        add(0, 0, 0, 0, 5, 0,        0, 0, 0, 0, 32'h40);

        // reset state
        msi_enable = 1'b1;
        msi_mme    = 3'd5;
        do_reset();
        chk("reset.req", 32'(app_msi_req), 32'h0);
        chk("reset.num", 32'(app_msi_num), 32'h0);
        chk("reset.pend", irq_pending, 32'h0);
        chk("reset.sent", 32'(irq_sent), 32'h0);
        chk("reset.tmo", 32'(irq_timeout), 32'h0);
        chk("const.tc", 32'(app_msi_tc), 32'h5);
        chk("const.func", 32'(app_msi_func_num), 32'h2);

        // driver + scoreboard over the vector table
        for (int i = 0; i < vq.size(); i++) begin
            if (vq[i].rst) do_reset();
            irq_req     = vq[i].req;
            irq_mask    = vq[i].mask;
            msi_enable  = vq[i].en;
            msi_mme     = vq[i].mme;
            app_msi_ack = vq[i].ack;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.req", i), 32'(app_msi_req), 32'(vq[i].x_req));
            chk($sformatf("v%0d.sent", i), 32'(irq_sent), 32'(vq[i].x_sent));
            chk($sformatf("v%0d.tmo", i), 32'(irq_timeout), 32'(vq[i].x_tmo));
            chk($sformatf("v%0d.pend", i), irq_pending, vq[i].x_pend);
            if (vq[i].x_req) chk($sformatf("v%0d.num", i), 32'(app_msi_num), 32'(vq[i].x_num));
        end

        // asynchronous reset while a request is outstanding
        irq_mask   = '0;
        msi_enable = 1'b1;
        msi_mme    = 3'd5;
        do_reset();
        irq_req = 32'h10;
        @(posedge clk);
        #1;
        irq_req = '0;
        n = 0;
        while (!app_msi_req && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("arst.req_seen", 32'(app_msi_req), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.req", 32'(app_msi_req), 32'h0);
        chk("arst.pend", irq_pending, 32'h0);
        chk("arst.sent", 32'(irq_sent), 32'h0);
        chk("arst.tmo", 32'(irq_timeout), 32'h0);
        @(negedge clk);
        rst_n       = 1'b1;
        app_msi_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("late_ack%0d.req", k), 32'(app_msi_req), 32'h0);
            chk($sformatf("late_ack%0d.sent", k), 32'(irq_sent), 32'h0);
            chk($sformatf("late_ack%0d.pend", k), irq_pending, 32'h0);
        end
        app_msi_ack = 1'b0;

        // report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
